fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 114 +++++++++++
 tb/tb_fetch_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer.
// Walks an external PC register and a byte-wide memory to assemble one- or
// two-byte instructions (bit W-1 of the opcode marks a two-byte instruction)
// and presents them to a consumer through a valid/ready handshake.
// A jump request in any state redirects the PC and discards in-flight work.
//
// Handshake: instr_valid is high only in HOLD; the instruction is consumed on
// a rising clk edge where instr_valid and instr_ready are both high. While
// instr_valid is high and instr_ready is low, all instr_* outputs hold steady.
module fetch_sequencer #(
    parameter int             N         = 8,
    parameter int             W         = 8,
    parameter logic [N-1:0]   RESET_VEC = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] pc_value,
    output logic         pc_read,
    output logic         pc_increment,
    output logic         pc_write,
    output logic [N-1:0] pc_load,
    output logic [N-1:0] mem_addr,
    output logic         mem_rd,
    input  logic [W-1:0] mem_data,
    input  logic         mem_ready,
    input  logic         jump_valid,
    input  logic [N-1:0] jump_addr,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic [W-1:0] instr_opcode,
    output logic [W-1:0] instr_operand,
    output logic [N-1:0] instr_pc,
    output logic [2:0]   state_dbg
);

    typedef enum logic [2:0] {
        ST_JUMP      = 3'd0,
        ST_FETCH_OP  = 3'd1,
        ST_INC_OP    = 3'd2,
        ST_FETCH_ARG = 3'd3,
        ST_INC_ARG   = 3'd4,
        ST_HOLD      = 3'd5
    } state_t;

    state_t       state;
    logic [N-1:0] jump_reg;

    // Sequencing and capture; a jump overrides every state, so a half-built
    // or held instruction is simply abandoned and never reaches HOLD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_JUMP;
            jump_reg      <= RESET_VEC;
            instr_opcode  <= '0;
            instr_operand <= '0;
            instr_pc      <= '0;
        end else if (jump_valid) begin
            jump_reg <= jump_addr;
            state    <= ST_JUMP;
        end else begin
            case (state)
                ST_JUMP: state <= ST_FETCH_OP;
                ST_FETCH_OP: begin
                    if (mem_ready) begin
                        instr_opcode  <= mem_data;
                        instr_operand <= '0;
                        instr_pc      <= pc_value;
                        state         <= ST_INC_OP;
                    end
                end
                ST_INC_OP: state <= instr_opcode[W-1] ? ST_FETCH_ARG : ST_HOLD;
                ST_FETCH_ARG: begin
                    if (mem_ready) begin
                        instr_operand <= mem_data;
                        state         <= ST_INC_ARG;
                    end
                end
                ST_INC_ARG: state <= ST_HOLD;
                ST_HOLD: begin
                    if (instr_ready) state <= ST_FETCH_OP;
                end
                default: state <= ST_JUMP;
            endcase
        end
    end

    // Moore decode of the PC/memory/consumer controls from the current state.
    always_comb begin
        pc_write     = 1'b0;
        pc_load      = '0;
        pc_read      = 1'b0;
        mem_rd       = 1'b0;
        mem_addr     = '0;
        pc_increment = 1'b0;
        instr_valid  = 1'b0;
        case (state)
            ST_JUMP: begin
                pc_write = 1'b1;
                pc_load  = jump_reg;
            end
            ST_FETCH_OP, ST_FETCH_ARG: begin
                pc_read  = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = pc_value;
            end
            ST_INC_OP, ST_INC_ARG: pc_increment = 1'b1;
            ST_HOLD:               instr_valid  = 1'b1;
            default: ;
        endcase
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a behavioural PC register and byte
// memory surround the DUT; checks follow the state sequence cycle by cycle.
module tb_fetch_sequencer;

    localparam int N = 8;
    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [N-1:0] pc_value;
    logic         pc_read, pc_increment, pc_write;
    logic [N-1:0] pc_load, mem_addr;
    logic         mem_rd;
    logic [W-1:0] mem_data;
    logic         mem_ready;
    logic         jump_valid;
    logic [N-1:0] jump_addr;
    logic         instr_valid, instr_ready;
    logic [W-1:0] instr_opcode, instr_operand;
    logic [N-1:0] instr_pc;
    logic [2:0]   state_dbg;

    fetch_sequencer #(.N(N), .W(W), .RESET_VEC(8'h10)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_value     (pc_value),
        .pc_read      (pc_read),
        .pc_increment (pc_increment),
        .pc_write     (pc_write),
        .pc_load      (pc_load),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .jump_valid   (jump_valid),
        .jump_addr    (jump_addr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_opcode (instr_opcode),
        .instr_operand(instr_operand),
        .instr_pc     (instr_pc),
        .state_dbg    (state_dbg)
    );

    // ---------------- environment models ----------------
    logic [W-1:0] mem [0:255];
    assign mem_data = mem[mem_addr];

    logic [N-1:0] pc_reg = '0;
    assign pc_value = pc_reg;

    int inc_count = 0;
    int hs_count  = 0;
    int bad_valid = 0;

    always @(posedge clk) begin
        if (pc_write)          pc_reg <= pc_load;
        else if (pc_increment) pc_reg <= pc_reg + 8'd1;
        if (pc_increment)      inc_count <= inc_count + 1;
        if (instr_valid && instr_ready) hs_count <= hs_count + 1;
        if (instr_valid && instr_opcode == 8'h9A) bad_valid <= bad_valid + 1;
    end

    // ---------------- checking ----------------
    int tests  = 0;
    int failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int inc_snap;
    int hs_snap;

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h12;
        mem[8'h40] = 8'h33;
        reset       = 1'b1;
        mem_ready   = 1'b0;
        jump_valid  = 1'b0;
        jump_addr   = '0;
        instr_ready = 1'b0;
        step();
        step();

        // outputs while reset is held
        check("rst_pc_write", pc_write, 1);
        check("rst_pc_load", pc_load, 8'h10);
        check("rst_pc_read", pc_read, 0);
        check("rst_pc_inc", pc_increment, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_opcode", instr_opcode, 0);
        check("rst_operand", instr_operand, 0);
        check("rst_ipc", instr_pc, 0);

        // release: cycle 0 JUMP to RESET_VEC, cycle 1 fetch from it
        reset = 1'b0;
        check("rel_c0_pc_write", pc_write, 1);
        check("rel_c0_pc_load", pc_load, 8'h10);
        step();
        check("rel_c1_mem_rd", mem_rd, 1);
        check("rel_c1_mem_addr", mem_addr, 8'h10);
        check("rel_c1_pc_read", pc_read, 1);
        check("rel_c1_pc_write", pc_write, 0);

        // jump during JUMP: latest target wins
        jump_valid = 1'b1; jump_addr = 8'h60;
        step();
        check("jj_first_load", pc_load, 8'h60);
        jump_addr = 8'h50;
        step();
        jump_valid = 1'b0;
        check("jj_latest_load", pc_load, 8'h50);
        step();
        check("jj_mem_addr", mem_addr, 8'h50);

        // one-byte 0x12 at 0x00 with memory always ready
        jump_valid = 1'b1; jump_addr = 8'h00;
        step();
        jump_valid = 1'b0;
        mem_ready  = 1'b1;
        inc_snap   = inc_count;
        check("one_c0_pc_write", pc_write, 1);
        check("one_c0_pc_load", pc_load, 8'h00);
        step();
        check("one_c1_mem_rd", mem_rd, 1);
        check("one_c1_valid", instr_valid, 0);
        step();
        check("one_c2_inc", pc_increment, 1);
        check("one_c2_mem_rd", mem_rd, 0);
        step();
        check("one_c3_valid", instr_valid, 1);
        check("one_c3_opcode", instr_opcode, 8'h12);
        check("one_c3_operand", instr_operand, 8'h00);
        check("one_c3_ipc", instr_pc, 8'h00);
        check("one_inc_pulses", inc_count - inc_snap, 1);

        // jump together with instr_ready in HOLD: consumed once, then JUMP
        mem[8'h00] = 8'h85;
        mem[8'h01] = 8'h3C;
        hs_snap     = hs_count;
        jump_valid  = 1'b1; jump_addr = 8'h00;
        instr_ready = 1'b1;
        step();
        jump_valid  = 1'b0;
        instr_ready = 1'b0;
        inc_snap    = inc_count;
        check("jhs_handshakes", hs_count - hs_snap, 1);
        check("jhs_pc_write", pc_write, 1);
        check("jhs_valid", instr_valid, 0);

        // two-byte 0x85,0x3C at 0x00
        step();
        check("two_c1_mem_addr", mem_addr, 8'h00);
        step();
        check("two_c2_inc", pc_increment, 1);
        step();
        check("two_c3_mem_rd", mem_rd, 1);
        check("two_c3_mem_addr", mem_addr, 8'h01);
        step();
        check("two_c4_inc", pc_increment, 1);
        check("two_c4_valid", instr_valid, 0);
        step();
        check("two_c5_valid", instr_valid, 1);
        check("two_c5_opcode", instr_opcode, 8'h85);
        check("two_c5_operand", instr_operand, 8'h3C);
        check("two_c5_ipc", instr_pc, 8'h00);
        check("two_inc_pulses", inc_count - inc_snap, 2);

        // memory stall then consumer stall
        mem[8'h02] = 8'h07;
        hs_snap     = hs_count;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("stall_hs", hs_count - hs_snap, 1);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("stall_mem_rd", mem_rd, 1);
            check("stall_mem_addr", mem_addr, 8'h02);
            step();
        end
        mem_ready = 1'b1;
        check("stall_mem_rd5", mem_rd, 1);
        step();
        check("stall_inc", pc_increment, 1);
        step();
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", instr_valid, 1);
            check("hold_mem_rd", mem_rd, 0);
            check("hold_opcode", instr_opcode, 8'h07);
            check("hold_operand", instr_operand, 8'h00);
            check("hold_ipc", instr_pc, 8'h02);
            step();
        end

        // jump while in FETCH_ARG discards the partial instruction
        mem[8'h03] = 8'h9A;
        mem[8'h04] = 8'h55;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        step();
        step();
        check("farg_mem_rd", mem_rd, 1);
        check("farg_mem_addr", mem_addr, 8'h04);
        jump_valid = 1'b1; jump_addr = 8'h40;
        step();
        jump_valid = 1'b0;
        mem_ready  = 1'b0;
        check("farg_j_pc_write", pc_write, 1);
        check("farg_j_pc_load", pc_load, 8'h40);
        check("farg_j_operand", instr_operand, 8'h00);
        step();
        check("farg_j_mem_addr", mem_addr, 8'h40);
        check("farg_j_valid", instr_valid, 0);
        mem_ready = 1'b1;
        step();
        step();
        check("after_j_valid", instr_valid, 1);
        check("after_j_opcode", instr_opcode, 8'h33);
        check("after_j_ipc", instr_pc, 8'h40);
        check("discarded_never_valid", bad_valid, 0);

        // reset pulse in HOLD drops instr_valid immediately
        #2;
        reset = 1'b1;
        #1;
        check("rhold_valid", instr_valid, 0);
        check("rhold_pc_write", pc_write, 1);
        check("rhold_pc_load", pc_load, 8'h10);
        check("rhold_opcode", instr_opcode, 0);
        step();
        reset = 1'b0;
        check("rhold_jump", pc_write, 1);
        step();
        check("rhold_mem_addr", mem_addr, 8'h10);
        check("rhold_mem_rd", mem_rd, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // global watchdog
    initial begin
        #20000;
        failed++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
